cpu_top: RTL and testbench
==========================

Name: cpu_top

Overview:
- Single-cycle RV64I integer core; top level of the processor, only clock and reset at the boundary.
- Fetches from an internal word-addressed instruction memory, executes, and writes back once per clock.
- Architectural state is observed and preloaded by benches through fixed hierarchical names (listed below), not through ports.

Parameters:
- XLEN, 64, datapath and register width.
- IMEM_WORDS, 100, instruction memory depth in 32-bit words (400 bytes).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rstn  input  1  synchronous, active-high reset (name kept per codebase; asserted = 1).

Behaviour:
- Required hierarchy:
  - instruction memory instance named instruction_cache_mem, holding byte array memory_8[0:4*IMEM_WORDS-1] and word array memory[0:IMEM_WORDS-1].
  - Fetch reads memory only; memory_8 is a preload staging array, never read by logic.
  - Word packing is big-endian: memory[i] = {memory_8[4i], memory_8[4i+1], memory_8[4i+2], memory_8[4i+3]}.
  - Neither array is reset by rstn.
- Architectural state names: PC register pc (XLEN bits); register file instance register_file with array regs[0:31].
- Reset, on a clock edge with rstn=1: pc <= RESET_PC; all regs <= 0.
- Fetch: instruction = memory[pc[8:2]] combinationally. If the word index >= IMEM_WORDS, the instruction is 0x00000000. pc[1:0] is ignored.
- Execute: one instruction commits per rising edge while rstn=0. Writeback and next-PC update happen on the same edge; latency is 1 cycle per instruction.
- Supported opcodes (standard RV64I encodings):
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; 6-bit shamt.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; shift amount rs2[5:0].
  - LUI, AUIPC: 32-bit U-immediate sign-extended to 64 bits.
  - JAL, JALR: rd <= pc+4; JALR target = (rs1+imm) & ~1.
  - BRANCH: BEQ, BNE, BLT, BGE, BLTU, BGEU; target = pc + sign-extended B-immediate.
- Immediates are always sign-extended to XLEN. Arithmetic wraps modulo 2^64.
- Writes to x0 are discarded; reads of x0 return 0.
- Register reads are combinational. A write and a read of the same register in one cycle: the read sees the old value (the single-cycle design makes this moot).
- Any other opcode, including an all-zero word: NOP (no register write, pc <= pc+4).
- Loads, stores, FENCE and SYSTEM are NOPs in this block.
- No trap on misaligned targets; pc is loaded as computed.
- Reset asserted mid-program overrides execution on that edge.
- pc wraps modulo 2^64.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH);
  - funct3/funct7 constants;
  - an alu_op_e enum;
  - XLEN.
- Sub-modules:
  - instr_mem (instance instruction_cache_mem);
  - reg_file (instance register_file);
  - one natural combinational sub-module alu (add/sub/shift/compare/logic plus branch compare).
- Decode, immediate generation and next-PC logic stay in cpu_top.

Test Plan:
- Reset: hold rstn=1 for 2 edges with a nonzero preload -> pc=0, all regs=0. Release -> pc=4 after the first edge.
- Reference program:
  - preload bytes 00 10 80 93 / 00 23 03 13 / 00 60 E2 63 / 10 11 81 93 / 00 00 00 00 / 10 12 02 13, rest zero;
  - run 10 cycles -> x1=1, x6=2, x3=0x101, x4=0x101, all other regs 0.
  - The BLTU at pc=8 is taken to pc=12; the zero word at pc=16 is a NOP.
- Branch not taken: same program with x1 preset so x1+1=3 > x6=2 -> pc goes 8 -> 12 sequentially, same x3/x4 results.
- Arithmetic edge cases:
  - ADDI x5,x0,-1 -> x5=0xFFFF_FFFF_FFFF_FFFF;
  - SRAI x5,x5,63 -> all ones; SRLI x5,x5,63 -> 1;
  - SLTU x7,x0,x5 -> 1; SLT x8,x5,x0 -> 1 (x5=-1).
- Jumps and x0:
  - JAL x1,+8 at pc=0 -> x1=4, pc=8;
  - JALR x0,0(x1) -> pc=4, x0 stays 0;
  - ADDI x0,x0,5 -> x0 reads 0.
- End of memory: run past pc=396 -> pc keeps incrementing by 4, fetches return 0 (NOP), no register changes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV64I definitions: datapath width, opcodes, funct fields, ALU operations.
// Ports: none (package).
package cpu_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB/SRA; allow_sub is clear for OP-IMM where funct7 is immediate
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt,
                                             input logic allow_sub);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU plus branch comparison flags.
// Ports: op, a, b in; result_c, eq_c, lt_c (signed), ltu_c (unsigned) out.
module alu
  import cpu_pkg::*;
(
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c,
  output logic            eq_c,
  output logic            lt_c,
  output logic            ltu_c
);

  logic [5:0] shamt;
  assign shamt = b[5:0];

  assign eq_c  = (a == b);
  assign lt_c  = ($signed(a) < $signed(b));
  assign ltu_c = (a < b);

  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_SLL:  result_c = a << shamt;
      ALU_SLT:  result_c = XLEN'(lt_c);
      ALU_SLTU: result_c = XLEN'(ltu_c);
      ALU_XOR:  result_c = a ^ b;
      ALU_SRL:  result_c = a >> shamt;
      ALU_SRA:  result_c = XLEN'($signed(a) >>> shamt);
      ALU_OR:   result_c = a | b;
      ALU_AND:  result_c = a & b;
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/instr_mem.sv
// Word-addressed instruction memory, preloaded externally through the arrays.
// Ports: clk; word_idx (pc[8:2]); instr_c combinational fetch, zero past the end.
module instr_mem #(
  parameter int unsigned WORDS = 100
) (
  input  logic        clk,
  input  logic [6:0]  word_idx,
  output logic [31:0] instr_c
);

  logic [7:0]  memory_8 [0:4*WORDS-1];
  logic [31:0] memory   [0:WORDS-1];

  // Storage only changes by external preload; the hold keeps both arrays as state
  always_ff @(posedge clk) begin
    memory_8 <= memory_8;
    memory   <= memory;
  end

  assign instr_c = (32'(word_idx) < WORDS) ? memory[word_idx] : 32'h0;

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN integer register file, x0 hardwired to zero.
// Ports: clk, rstn (sync, active-high); we/waddr/wdata write port; two comb read ports.
module reg_file
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1_c,
  output logic [XLEN-1:0] rdata2_c
);

  logic [XLEN-1:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1_c = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2_c = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_top.sv
// Single-cycle RV64I integer core: fetch, decode, execute and writeback each clock.
// Ports: clk; rstn (synchronous, active-high reset).
module cpu_top
  import cpu_pkg::*;
#(
  parameter int unsigned     IMEM_WORDS = 100,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic clk,
  input logic rstn
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic [31:0]     instr;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b, alu_res;
  logic            alu_eq, alu_lt, alu_ltu;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic            taken;

  instr_mem #(.WORDS(IMEM_WORDS)) instruction_cache_mem (
    .clk      (clk),
    .word_idx (pc[8:2]),
    .instr_c  (instr)
  );

  reg_file register_file (
    .clk      (clk),
    .rstn     (rstn),
    .we       (we),
    .waddr    (rd),
    .wdata    (wdata),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rs1_val),
    .rdata2_c (rs2_val)
  );

  alu u_alu (
    .op       (alu_op),
    .a        (rs1_val),
    .b        (alu_b),
    .result_c (alu_res),
    .eq_c     (alu_eq),
    .lt_c     (alu_lt),
    .ltu_c    (alu_ltu)
  );

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign pc_plus4 = pc + XLEN'(4);

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  // ALU operand and operation select; OP-IMM shifts use instr[30] as the arithmetic flag
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = rs2_val;
    case (opcode)
      OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_op_from_f3(funct3, instr[30], 1'b0);
      end
      OP:      alu_op = alu_op_from_f3(funct3, funct7 == F7_ALT, 1'b1);
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = alu_eq;
      F3_BNE:  taken = !alu_eq;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Writeback and next-PC; unsupported opcodes fall through as NOPs
  always_comb begin
    we      = 1'b0;
    wdata   = alu_res;
    next_pc = pc_plus4;
    case (opcode)
      OP_IMM, OP: we = 1'b1;
      LUI: begin
        we    = 1'b1;
        wdata = imm_u;
      end
      AUIPC: begin
        we    = 1'b1;
        wdata = pc + imm_u;
      end
      JAL: begin
        we      = 1'b1;
        wdata   = pc_plus4;
        next_pc = pc + imm_j;
      end
      JALR: begin
        we      = 1'b1;
        wdata   = pc_plus4;
        next_pc = (rs1_val + imm_i) & ~XLEN'(1);
      end
      BRANCH: if (taken) next_pc = pc + imm_b;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) pc <= RESET_PC;
    else      pc <= next_pc;
  end

endmodule

// File: tb/tb_cpu_top.sv
module tb_cpu_top;

  localparam int IMEM_WORDS = 100;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  cpu_top dut (.clk(clk), .rstn(rstn));

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic [63:0] m_x   [0:31];
  logic [63:0] m_pc;
  logic [31:0] m_mem [0:IMEM_WORDS-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
  endfunction

  // ---------------- memory / register preload ----------------
  task automatic load_word(input int i, input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24]; b1 = w[23:16]; b2 = w[15:8]; b3 = w[7:0];
    m_mem[i] = w;
    dut.instruction_cache_mem.memory_8[4*i]   = b0;
    dut.instruction_cache_mem.memory_8[4*i+1] = b1;
    dut.instruction_cache_mem.memory_8[4*i+2] = b2;
    dut.instruction_cache_mem.memory_8[4*i+3] = b3;
    dut.instruction_cache_mem.memory[i] = {b0, b1, b2, b3};
  endtask

  task automatic fill_mem(input logic [31:0] w);
    for (int i = 0; i < IMEM_WORDS; i++) load_word(i, w);
  endtask

  task automatic set_reg(input int r, input logic [63:0] v);
    dut.register_file.regs[r] = v;
    m_x[r] = v;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_fetch(input logic [63:0] pc);
    int idx;
    idx = int'(pc[8:2]);
    return (idx < IMEM_WORDS) ? m_mem[idx] : 32'h0;
  endfunction

  function automatic logic [63:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic is_imm, input logic [63:0] a,
                                        input logic [63:0] b);
    int sh;
    sh = int'(b[5:0]);
    case (f3)
      3'd0: return (!is_imm && alt) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: return (a < b) ? 64'd1 : 64'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 64'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step(input logic rst);
    logic [31:0] ins;
    logic [63:0] a, b, immi, immb, immu, immj, nxt, val;
    logic        wr, take;
    if (rst) begin
      m_pc = 64'd0;
      for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
      return;
    end
    ins  = m_fetch(m_pc);
    a    = m_x[ins[19:15]];
    b    = m_x[ins[24:20]];
    immi = 64'($signed(ins[31:20]));
    immb = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    immu = 64'($signed({ins[31:12], 12'h000}));
    immj = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    nxt  = m_pc + 64'd4;
    wr   = 1'b0;
    val  = 64'd0;
    take = 1'b0;
    case (ins[6:0])
      7'h13: begin wr = 1'b1; val = arith(ins[14:12], ins[30], 1'b1, a, immi); end
      7'h33: begin wr = 1'b1; val = arith(ins[14:12], ins[30], 1'b0, a, b); end
      7'h37: begin wr = 1'b1; val = immu; end
      7'h17: begin wr = 1'b1; val = m_pc + immu; end
      7'h6F: begin wr = 1'b1; val = m_pc + 64'd4; nxt = m_pc + immj; end
      7'h67: begin wr = 1'b1; val = m_pc + 64'd4; nxt = (a + immi) & ~64'd1; end
      7'h63: begin
        case (ins[14:12])
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) nxt = m_pc + immb;
      end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = val;
    m_pc = nxt;
  endtask

  // one clock: drive reset, let the edge pass, advance model, compare pc
  task automatic tick(input logic rst);
    rstn = rst;
    @(posedge clk);
    #1;
    model_step(rst);
    chk("pc", dut.pc, m_pc);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) chk(tag, dut.register_file.regs[i], m_x[i]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [5:0]  sh;
    logic        alt;
    int          sel;
    rd  = 5'($urandom_range(0, 15));
    rs1 = 5'($urandom_range(0, 15));
    rs2 = 5'($urandom_range(0, 15));
    alt = 1'($urandom_range(0, 1));
    sh  = 6'($urandom_range(0, 63));
    sel = int'($urandom_range(0, 9));
    case (sel)
      0, 9: begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
        return enc_i(7'h13, rd, f3, rs1, 12'($urandom));
      end
      1: begin
        if (alt) return enc_i(7'h13, rd, 3'd5, rs1, {6'b010000, sh});
        f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
        return enc_i(7'h13, rd, f3, rs1, {6'b000000, sh});
      end
      2: begin
        f3 = 3'($urandom_range(0, 7));
        return enc_r((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      end
      3: return {20'($urandom), rd, 7'h37};
      4: return {20'($urandom), rd, 7'h17};
      5: return enc_j(rd, 21'(int'($urandom_range(0, 32)) * 4 - 64 + (alt ? 2 : 0)));
      6: return enc_i(7'h67, rd, 3'd0, rs1, 12'($urandom_range(0, 4095)));
      7: begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
        return enc_b(f3, rs1, rs2, 13'(int'($urandom_range(0, 32)) * 4 - 64));
      end
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h0;
          1: return {25'($urandom), 7'h03};
          2: return {25'($urandom), 7'h23};
          3: return {25'($urandom), 7'h0F};
          default: return {25'($urandom), 7'h73};
        endcase
      end
    endcase
  endfunction

  logic [63:0] exp_ref [0:31];

  initial begin
    // reference program; other words zero
    fill_mem(32'h0);
    load_word(0, 32'h00108093);
    load_word(1, 32'h00230313);
    load_word(2, 32'h0060E263);
    load_word(3, 32'h10118193);
    load_word(4, 32'h00000000);
    load_word(5, 32'h10120213);

    // reset with nonzero state preloaded
    #1;
    for (int i = 1; i < 32; i++) dut.register_file.regs[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
    dut.pc = 64'h1234;
    tick(1'b1);
    tick(1'b1);
    chk("rst_pc", dut.pc, 64'd0);
    for (int i = 0; i < 32; i++) chk("rst_reg", dut.register_file.regs[i], 64'd0);
    tick(1'b0);
    chk("pc_release", dut.pc, 64'd4);
    for (int c = 2; c <= 10; c++) begin
      tick(1'b0);
      if (c == 3) chk("bltu_taken_pc", dut.pc, 64'd12);
    end
    chk("ref_pc_end", dut.pc, 64'd40);
    for (int i = 0; i < 32; i++) exp_ref[i] = 64'd0;
    exp_ref[1] = 64'd1; exp_ref[6] = 64'd2; exp_ref[3] = 64'h101; exp_ref[4] = 64'h101;
    for (int i = 0; i < 32; i++) chk("ref_reg", dut.register_file.regs[i], exp_ref[i]);
    check_regs("ref_model");

    // same program, branch not taken (x1 starts at 2)
    tick(1'b1);
    set_reg(1, 64'd2);
    for (int c = 1; c <= 10; c++) begin
      tick(1'b0);
      if (c == 3) chk("bltu_not_taken_pc", dut.pc, 64'd12);
    end
    chk("nt_x1", dut.register_file.regs[1], 64'd3);
    chk("nt_x3", dut.register_file.regs[3], 64'h101);
    chk("nt_x4", dut.register_file.regs[4], 64'h101);
    check_regs("nt_model");

    // arithmetic edge cases
    fill_mem(32'h0);
    load_word(0, enc_i(7'h13, 5'd5, 3'd0, 5'd0, 12'hFFF));
    load_word(1, enc_i(7'h13, 5'd9, 3'd5, 5'd5, 12'h43F));
    load_word(2, enc_i(7'h13, 5'd10, 3'd5, 5'd5, 12'h03F));
    load_word(3, enc_r(7'h00, 5'd5, 5'd0, 3'd3, 5'd7));
    load_word(4, enc_r(7'h00, 5'd0, 5'd5, 3'd2, 5'd8));
    tick(1'b1);
    repeat (5) tick(1'b0);
    chk("addi_m1", dut.register_file.regs[5], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("srai63", dut.register_file.regs[9], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("srli63", dut.register_file.regs[10], 64'd1);
    chk("sltu", dut.register_file.regs[7], 64'd1);
    chk("slt", dut.register_file.regs[8], 64'd1);

    // jumps and x0
    fill_mem(32'h0);
    load_word(0, enc_j(5'd1, 21'd8));
    load_word(1, enc_i(7'h13, 5'd0, 3'd0, 5'd0, 12'd5));
    load_word(2, enc_i(7'h67, 5'd0, 3'd0, 5'd1, 12'd0));
    tick(1'b1);
    tick(1'b0);
    chk("jal_pc", dut.pc, 64'd8);
    chk("jal_x1", dut.register_file.regs[1], 64'd4);
    tick(1'b0);
    chk("jalr_pc", dut.pc, 64'd4);
    chk("jalr_x0", dut.register_file.regs[0], 64'd0);
    tick(1'b0);
    chk("addi_x0_pc", dut.pc, 64'd8);
    chk("addi_x0", dut.register_file.regs[0], 64'd0);

    // past the end of memory: in-range words are NOP loads, beyond fetches zero
    fill_mem(32'h0000_0003);
    tick(1'b1);
    chk("fetch_in_range", 64'(dut.instr), 64'h3);
    for (int i = 1; i < 32; i++) set_reg(i, {$urandom, $urandom});
    repeat (120) tick(1'b0);
    chk("oob_pc", dut.pc, 64'd480);
    chk("oob_fetch", 64'(dut.instr), 64'd0);
    check_regs("oob_reg");

    // randomized programs against the model, with occasional mid-run reset
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < IMEM_WORDS; i++) load_word(i, rand_instr());
      tick(1'b1);
      for (int i = 1; i < 32; i++) set_reg(i, {$urandom, $urandom});
      for (int c = 0; c < 200; c++) tick($urandom_range(0, 63) == 0);
      check_regs("rand_reg");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
